// File: rtl/writeback_unit.sv
// Dual-pipe writeback delay line: results ride a per-pipe shift register to the
// commit stage, feeding register-file writes and registered operand forwarding.
module writeback_unit #(
    parameter int unsigned DEPTH = 7,
    parameter int unsigned DW    = 128,
    parameter int unsigned AW    = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               res_valid_0,
    input  logic               res_valid_1,
    input  logic [AW-1:0]      res_addr_0,
    input  logic [AW-1:0]      res_addr_1,
    input  logic [DW-1:0]      res_data_0,
    input  logic [DW-1:0]      res_data_1,
    input  logic [2:0]         res_dly_0,
    input  logic [2:0]         res_dly_1,
    input  logic               flush,
    input  logic [DW+AW-1:0]   op_in_0,
    input  logic [DW+AW-1:0]   op_in_1,
    input  logic [DW+AW-1:0]   op_in_2,
    input  logic [DW+AW-1:0]   op_in_3,
    input  logic [DW+AW-1:0]   op_in_4,
    input  logic [DW+AW-1:0]   op_in_5,
    output logic [DW+AW-1:0]   op_out_0,
    output logic [DW+AW-1:0]   op_out_1,
    output logic [DW+AW-1:0]   op_out_2,
    output logic [DW+AW-1:0]   op_out_3,
    output logic [DW+AW-1:0]   op_out_4,
    output logic [DW+AW-1:0]   op_out_5,
    output logic               wr_en_0,
    output logic               wr_en_1,
    output logic [AW-1:0]      wr_addr_0,
    output logic [AW-1:0]      wr_addr_1,
    output logic [DW-1:0]      wr_data_0,
    output logic [DW-1:0]      wr_data_1,
    output logic               err_collide_0,
    output logic               err_collide_1,
    output logic [15:0]        commit_cnt
);

    localparam int unsigned NP   = 2;
    localparam int unsigned NOP  = 6;
    localparam int unsigned OW   = DW + AW;
    localparam int unsigned LAST = DEPTH - 1;

    logic          vld_q  [NP][DEPTH];
    logic          vld_d  [NP][DEPTH];
    logic [AW-1:0] addr_q [NP][DEPTH];
    logic [AW-1:0] addr_d [NP][DEPTH];
    logic [DW-1:0] data_q [NP][DEPTH];
    logic [DW-1:0] data_d [NP][DEPTH];
    logic          err_q  [NP];
    logic          err_d  [NP];
    logic [15:0]   cnt_q;
    logic [15:0]   cnt_d;
    logic [OW-1:0] opo_q  [NOP];
    logic [OW-1:0] opo_d  [NOP];

    logic          off_v   [NP];
    logic [AW-1:0] off_a   [NP];
    logic [DW-1:0] off_dat [NP];
    logic [2:0]    off_dly [NP];
    logic [2:0]    dly_eff [NP];
    logic          ins     [NP];
    logic [OW-1:0] opi     [NOP];

    assign off_v[0]   = res_valid_0;
    assign off_v[1]   = res_valid_1;
    assign off_a[0]   = res_addr_0;
    assign off_a[1]   = res_addr_1;
    assign off_dat[0] = res_data_0;
    assign off_dat[1] = res_data_1;
    assign off_dly[0] = res_dly_0;
    assign off_dly[1] = res_dly_1;

    assign opi[0] = op_in_0;
    assign opi[1] = op_in_1;
    assign opi[2] = op_in_2;
    assign opi[3] = op_in_3;
    assign opi[4] = op_in_4;
    assign opi[5] = op_in_5;

    // Clamp delay; a flush only lets a zero-delay result straight into commit
    always_comb begin : clamp_accept
        for (int p = 0; p < NP; p++) begin
            dly_eff[p] = (32'(off_dly[p]) > LAST) ? 3'(LAST) : off_dly[p];
            ins[p]     = off_v[p] && (!flush || dly_eff[p] == 3'd0);
        end
    end

    always_comb begin : shift_insert
        for (int p = 0; p < NP; p++) begin
            err_d[p]     = err_q[p];
            vld_d[p][0]  = 1'b0;
            addr_d[p][0] = addr_q[p][0];
            data_d[p][0] = data_q[p][0];
            if (ins[p] && 32'(dly_eff[p]) == LAST) begin
                vld_d[p][0]  = 1'b1;
                addr_d[p][0] = off_a[p];
                data_d[p][0] = off_dat[p];
            end
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[p][k]  = vld_q[p][k-1] && !flush;
                addr_d[p][k] = addr_q[p][k-1];
                data_d[p][k] = data_q[p][k-1];
                if (ins[p] && (32'(dly_eff[p]) + 32'(k) == LAST)) begin
                    // A live entry about to land in the target stage is lost
                    if (!flush && vld_q[p][k-1]) begin
                        err_d[p] = 1'b1;
                    end
                    vld_d[p][k]  = 1'b1;
                    addr_d[p][k] = off_a[p];
                    data_d[p][k] = off_dat[p];
                end
            end
        end
    end

    // Same-address double commit: the odd pipe's write wins
    assign wr_en_1   = vld_q[1][LAST];
    assign wr_en_0   = vld_q[0][LAST] && !(vld_q[1][LAST] && addr_q[0][LAST] == addr_q[1][LAST]);
    assign wr_addr_0 = addr_q[0][LAST];
    assign wr_addr_1 = addr_q[1][LAST];
    assign wr_data_0 = data_q[0][LAST];
    assign wr_data_1 = data_q[1][LAST];

    assign cnt_d = cnt_q + 16'(wr_en_0) + 16'(wr_en_1);

    // Scan oldest to youngest so the youngest (lowest stage, odd pipe on ties) wins
    always_comb begin : forward
        for (int i = 0; i < NOP; i++) begin
            opo_d[i] = opi[i];
            for (int k = int'(LAST); k >= 0; k--) begin
                for (int p = 0; p < NP; p++) begin
                    if (vld_q[p][k] && addr_q[p][k] == opi[i][OW-1:DW]) begin
                        opo_d[i][DW-1:0] = data_q[p][k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin : ctrl_regs
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                err_q[p] <= 1'b0;
                for (int k = 0; k < DEPTH; k++) begin
                    vld_q[p][k] <= 1'b0;
                end
            end
            for (int i = 0; i < NOP; i++) begin
                opo_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            opo_q <= opo_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload is qualified by the valid bits, so it carries no reset
    always_ff @(posedge clk) begin : payload_regs
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign op_out_0      = opo_q[0];
    assign op_out_1      = opo_q[1];
    assign op_out_2      = opo_q[2];
    assign op_out_3      = opo_q[3];
    assign op_out_4      = opo_q[4];
    assign op_out_5      = opo_q[5];
    assign err_collide_0 = err_q[0];
    assign err_collide_1 = err_q[1];
    assign commit_cnt    = cnt_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: commit scoreboard, forwarding vector table and
// hand sequences for priority, collision, flush and mid-stream reset.
module tb_writeback_unit;

    localparam int unsigned DEPTH = 7;
    localparam int unsigned DW    = 128;
    localparam int unsigned AW    = 7;
    localparam int unsigned OW    = DW + AW;
    localparam int          LAST  = DEPTH - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          res_valid_0 = 1'b0, res_valid_1 = 1'b0;
    logic [AW-1:0] res_addr_0 = '0, res_addr_1 = '0;
    logic [DW-1:0] res_data_0 = '0, res_data_1 = '0;
    logic [2:0]    res_dly_0 = '0, res_dly_1 = '0;
    logic          flush = 1'b0;
    logic [OW-1:0] opi [6];
    logic [OW-1:0] opo [6];
    logic          wr_en_0, wr_en_1;
    logic [AW-1:0] wr_addr_0, wr_addr_1;
    logic [DW-1:0] wr_data_0, wr_data_1;
    logic          err_collide_0, err_collide_1;
    logic [15:0]   commit_cnt;

    writeback_unit #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .res_valid_0(res_valid_0), .res_valid_1(res_valid_1),
        .res_addr_0(res_addr_0), .res_addr_1(res_addr_1),
        .res_data_0(res_data_0), .res_data_1(res_data_1),
        .res_dly_0(res_dly_0), .res_dly_1(res_dly_1),
        .flush(flush),
        .op_in_0(opi[0]), .op_in_1(opi[1]), .op_in_2(opi[2]),
        .op_in_3(opi[3]), .op_in_4(opi[4]), .op_in_5(opi[5]),
        .op_out_0(opo[0]), .op_out_1(opo[1]), .op_out_2(opo[2]),
        .op_out_3(opo[3]), .op_out_4(opo[4]), .op_out_5(opo[5]),
        .wr_en_0(wr_en_0), .wr_en_1(wr_en_1),
        .wr_addr_0(wr_addr_0), .wr_addr_1(wr_addr_1),
        .wr_data_0(wr_data_0), .wr_data_1(wr_data_1),
        .err_collide_0(err_collide_0), .err_collide_1(err_collide_1),
        .commit_cnt(commit_cnt)
    );

    typedef struct {
        int            due;
        int            pipe;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        int            pipe;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            dly;
        int            gap;
        int            idx;
        logic [AW-1:0] tag;
        logic [DW-1:0] in_data;
        bit            hit;
    } fwd_vec_t;

    exp_t     sb[$];
    fwd_vec_t tbl[8];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       exp_cnt = 0;
    bit       seen[2];

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        res_valid_0 = 1'b0;
        res_valid_1 = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic offer(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int dly, input bit keep);
        int de;
        de = (dly > LAST) ? LAST : dly;
        if (p == 0) begin
            res_valid_0 = 1'b1; res_addr_0 = a; res_data_0 = d; res_dly_0 = 3'(dly);
        end else begin
            res_valid_1 = 1'b1; res_addr_1 = a; res_data_1 = d; res_dly_1 = 3'(dly);
        end
        if (keep) sb.push_back('{cyc + 1 + de, p, a, d});
    endtask

    // Commit scoreboard: every due write must appear exactly in its cycle
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            exp_cnt = 0;
        end
        chk("commit_cnt", OW'(commit_cnt), OW'(exp_cnt[15:0]));
        seen[0] = 1'b0;
        seen[1] = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                if (sb[i].pipe == 0) begin
                    chk("wr_en_0", OW'(wr_en_0), OW'(1));
                    chk("wr_0 addr/data", {wr_addr_0, wr_data_0}, {sb[i].addr, sb[i].data});
                end else begin
                    chk("wr_en_1", OW'(wr_en_1), OW'(1));
                    chk("wr_1 addr/data", {wr_addr_1, wr_data_1}, {sb[i].addr, sb[i].data});
                end
                seen[sb[i].pipe] = 1'b1;
                exp_cnt++;
                sb.delete(i);
            end
        end
        if (!seen[0]) chk("wr_en_0 idle", OW'(wr_en_0), OW'(0));
        if (!seen[1]) chk("wr_en_1 idle", OW'(wr_en_1), OW'(0));
    end

    initial begin
        logic [OW-1:0] expw;
        logic [DW-1:0] da, db;

        tbl[0] = '{1, 7'd9,  {4{32'h0909_0909}}, 3, 2, 2, 7'd9,  {4{32'h5555_0000}}, 1'b1};
        tbl[1] = '{0, 7'd20, {4{32'h2020_2020}}, 2, 0, 0, 7'd20, {4{32'h5555_0001}}, 1'b0};
        tbl[2] = '{0, 7'd21, {4{32'h2121_2121}}, 2, 3, 1, 7'd21, {4{32'h5555_0002}}, 1'b1};
        tbl[3] = '{1, 7'd22, {4{32'h2222_2222}}, 1, 3, 3, 7'd22, {4{32'h5555_0003}}, 1'b0};
        tbl[4] = '{0, 7'd23, {4{32'h2323_2323}}, 6, 1, 4, 7'd23, {4{32'h5555_0004}}, 1'b1};
        tbl[5] = '{1, 7'd24, {4{32'h2424_2424}}, 0, 1, 5, 7'd25, {4{32'h5555_0005}}, 1'b0};
        tbl[6] = '{0, 7'd26, {4{32'h2626_2626}}, 7, 7, 0, 7'd26, {4{32'h5555_0006}}, 1'b1};
        tbl[7] = '{1, 7'd27, {4{32'h2727_2727}}, 5, 6, 1, 7'd27, {4{32'h5555_0007}}, 1'b1};
        for (int i = 0; i < 6; i++) opi[i] = '0;

        #1 reset = 1'b0;
        #1;
        chk("reset wr_en_0", OW'(wr_en_0), OW'(0));
        chk("reset op_out_0", opo[0], OW'(0));
        chk("reset err_collide_0", OW'(err_collide_0), OW'(0));
        chk("reset commit_cnt", OW'(commit_cnt), OW'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Zero-delay even offer commits on the next cycle
        offer(0, 7'd5, {16{8'hAA}}, 0, 1'b1);
        tick();
        chk("d0 wr_en_0", OW'(wr_en_0), OW'(1));
        chk("d0 wr_addr_0", OW'(wr_addr_0), OW'(5));
        tick();
        chk("d0 commit_cnt", OW'(commit_cnt), OW'(1));
        repeat (2) tick();

        for (int r = 0; r < 8; r++) begin
            offer(tbl[r].pipe, tbl[r].addr, tbl[r].data, tbl[r].dly, 1'b1);
            repeat (tbl[r].gap) tick();
            opi[tbl[r].idx] = {tbl[r].tag, tbl[r].in_data};
            tick();
            expw = {tbl[r].tag, tbl[r].hit ? tbl[r].data : tbl[r].in_data};
            chk($sformatf("fwd vec %0d", r), opo[tbl[r].idx], expw);
            opi[tbl[r].idx] = '0;
            repeat (LAST + 2) tick();
        end

        // Lower stage beats higher stage
        da = {4{32'hA0A0_0030}};
        db = {4{32'hB0B0_0030}};
        offer(0, 7'd30, da, 5, 1'b1);
        offer(1, 7'd30, db, 3, 1'b1);
        tick();
        opi[0] = {7'd30, {4{32'h0BAD_0000}}};
        tick();
        chk("fwd lower stage wins", opo[0], {7'd30, da});
        opi[0] = '0;
        repeat (LAST + 2) tick();

        // Same stage: odd pipe wins forwarding and the same-address commit
        da = {4{32'hC0C0_0017}};
        db = {4{32'hE0E0_0017}};
        offer(0, 7'd17, da, 4, 1'b0);
        offer(1, 7'd17, db, 4, 1'b1);
        tick();
        opi[1] = {7'd17, {4{32'h0BAD_0001}}};
        tick();
        chk("fwd odd pipe wins", opo[1], {7'd17, db});
        opi[1] = '0;
        repeat (3) tick();
        chk("dup addr wr_en_0", OW'(wr_en_0), OW'(0));
        chk("dup addr wr_en_1", OW'(wr_en_1), OW'(1));
        repeat (LAST + 2) tick();

        // Flush drops in-flight entries; commit stage and D=0 offers survive
        da = {4{32'h5050_5050}};
        offer(0, 7'd50, da, 4, 1'b0);
        offer(1, 7'd51, {4{32'h5151_5151}}, 6, 1'b0);
        tick();
        offer(0, 7'd52, {4{32'h5252_5252}}, 0, 1'b1);
        tick();
        flush = 1'b1;
        offer(1, 7'd53, {4{32'h5353_5353}}, 0, 1'b1);
        offer(0, 7'd54, {4{32'h5454_5454}}, 1, 1'b0);
        opi[3] = {7'd50, {4{32'h0BAD_0003}}};
        tick();
        chk("fwd during flush", opo[3], {7'd50, da});
        opi[3] = '0;
        repeat (LAST + 2) tick();
        chk("flush err_collide_0", OW'(err_collide_0), OW'(0));

        // Overwrite collision on the even pipe
        offer(0, 7'd40, {4{32'h4040_4040}}, 2, 1'b0);
        tick();
        chk("pre-collide err_collide_0", OW'(err_collide_0), OW'(0));
        offer(0, 7'd41, {4{32'h4141_4141}}, 1, 1'b1);
        tick();
        chk("collide err_collide_0", OW'(err_collide_0), OW'(1));
        chk("collide err_collide_1", OW'(err_collide_1), OW'(0));
        repeat (LAST + 2) tick();

        // Mid-stream reset with entries in flight and one in commit
        opi[0] = {7'd3, {4{32'hC0DE_0003}}};
        offer(0, 7'd60, {4{32'h6060_6060}}, 6, 1'b0);
        offer(1, 7'd61, {4{32'h6161_6161}}, 6, 1'b0);
        tick();
        offer(0, 7'd62, {4{32'h6262_6262}}, 4, 1'b0);
        offer(1, 7'd63, {4{32'h6363_6363}}, 3, 1'b0);
        tick();
        offer(0, 7'd64, {4{32'h6464_6464}}, 6, 1'b0);
        offer(1, 7'd65, {4{32'h6565_6565}}, 0, 1'b0);
        tick();
        chk("pre-reset wr_en_1", OW'(wr_en_1), OW'(1));
        chk("pre-reset op_out_0", opo[0], {7'd3, {4{32'hC0DE_0003}}});
        chk("sticky err_collide_0", OW'(err_collide_0), OW'(1));
        reset = 1'b0;
        #1;
        chk("async wr_en_1", OW'(wr_en_1), OW'(0));
        chk("async op_out_0", opo[0], OW'(0));
        chk("async err_collide_0", OW'(err_collide_0), OW'(0));
        chk("async commit_cnt", OW'(commit_cnt), OW'(0));
        offer(0, 7'd66, {4{32'h6666_6666}}, 0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        repeat (LAST + 3) tick();
        chk("post-reset commit_cnt", OW'(commit_cnt), OW'(0));
        opi[0] = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DEPTH, default 7: writeback stages per pipe, numbered 0..DEPTH-1; stage DEPTH-1 is the commit stage.
REQ-002 Parameter DW, default 128: result data width.
REQ-003 Parameter AW, default 7: register address width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 res_valid_0/1  input  1  result offered by the even (0) or odd (1) pipe this cycle.
REQ-007 res_addr_0/1  input  AW  destination register of the offered result.
REQ-008 res_data_0/1  input  DW  result value.
REQ-009 res_dly_0/1  input  3  extra delay D, 0..DEPTH-1; a D outside that range is clamped to DEPTH-1.
REQ-010 flush  input  1  discard all in-flight results not yet in the commit stage.
REQ-011 op_in_0..op_in_5  input  DW+AW  operand words; bits [0:DW-1] are data, bits [DW:DW+AW-1] are the source register tag.
REQ-012 op_out_0..op_out_5  output  DW+AW  registered, forwarded operands.
REQ-013 wr_en_0/1, wr_addr_0/1 [AW], wr_data_0/1 [DW]  output  register-file write ports, driven combinationally from the commit stage.
REQ-014 err_collide_0/1  output  1  sticky; an insertion overwrote a valid entry in that pipe.
REQ-015 commit_cnt  output  16  total committed writes across both pipes; wraps modulo 2^16.

Function
REQ-016 Each pipe holds DEPTH stages; each stage stores {valid, addr, data}.
REQ-017 Every cycle, each pipe's stage k moves to stage k+1; the commit-stage contents are dropped after that cycle.
REQ-018 An accepted result with delay D enters stage DEPTH-1-D at the edge, so the register-file write occurs D+1 cycles after it is offered.
REQ-019 If the entry shifting into the target stage is valid (stage DEPTH-2-D when D<DEPTH-1), the new result overwrites it and err_collide_p sets; D=DEPTH-1 never collides.
REQ-020 Commit outputs: wr_en_p = stage DEPTH-1 valid of pipe p; wr_addr_p and wr_data_p come from that same stage.
REQ-021 If both commit stages are valid with equal addr, wr_en_0 is forced to 0 and the odd pipe wins.
REQ-022 commit_cnt increments by the number of asserted wr_en outputs per cycle (0, 1 or 2).
REQ-023 flush clears the valid bit of stages 0..DEPTH-2 in both pipes at the edge; the commit stage still writes that cycle.
REQ-024 flush has priority over same-cycle insertions: results offered during a flush are dropped unless D=0.
REQ-025 Forwarding, per operand i: compare the tag of op_in_i with the addr of every valid stage of both pipes, using pre-edge state.
REQ-026 Forwarding priority: lowest stage index wins (last to commit); at equal index the odd pipe wins.
REQ-027 Offers in the current cycle are not visible to forwarding until the next cycle.
REQ-028 op_out_i is registered with 1-cycle latency: data is the winning stage data, or op_in_i data if there is no match; the tag always passes unchanged.
REQ-029 Forwarding ignores flush in the same cycle and uses pre-flush contents.

Reset
REQ-030 When reset=0, asynchronously: all stage valid bits are 0, op_out_* = 0, wr_en_* = 0, err_collide_* = 0, commit_cnt = 0.
REQ-031 Stage addr/data need no reset; outputs that depend on them are gated by valid.
REQ-032 Offers during reset are lost; operation resumes on the first rising edge after reset goes to 1.

Verification
REQ-033 Even offer addr=5, data=0xAA..AA, D=0 -> wr_en_0=1, wr_addr_0=5 one cycle later; commit_cnt=1.
REQ-034 Odd offer addr=9, D=3; op_in_2 tag=9 presented two cycles later -> op_out_2 data = the offered value on the next cycle.
REQ-035 Even D=2 offer, then next cycle even D=1 offer -> err_collide_0=1, only the second value commits, and the flag holds until reset.
REQ-036 Both pipes commit addr=17 in the same cycle -> wr_en_0=0, wr_en_1=1, commit_cnt increments by 1.
REQ-037 Offers with D=4 and D=6, then flush two cycles later -> neither commits; an entry already in the commit stage still writes.
REQ-038 reset=0 mid-stream with 5 entries in flight -> outputs are zero immediately, and no write follows after release.
